// File: rtl/projectile_slot_arbiter.sv
// projectile_slot_arbiter: shares projectile slots between the player cannon
// (slot 0) and the monster columns (slots 1..NUM_SLOTS-1). Schedules at most
// one player and one monster launch per frame, gated by per-side cooldowns.
// Optional feature macro: ARBITER_STATS_EN (launch/denial statistics ports).
module projectile_slot_arbiter #(
  parameter int unsigned NUM_SLOTS        = 4,
  parameter int unsigned NUM_MONSTER_REQ  = 8,
  parameter int unsigned PLAYER_COOLDOWN  = 15,
  parameter int unsigned MONSTER_COOLDOWN = 30,
  parameter int unsigned CD_W             = 6
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               startOfFrame,
  input  logic                               game_enable,
  input  logic                               player_fire_req,
  input  logic [NUM_MONSTER_REQ-1:0]         monster_fire_req,
  input  logic [NUM_SLOTS-1:0]               slot_free,
  output logic [NUM_SLOTS-1:0]               slot_busy,
  output logic [NUM_SLOTS-1:0]               slot_launch,
  output logic [$clog2(NUM_MONSTER_REQ)-1:0] launch_src_idx
`ifdef ARBITER_STATS_EN
  ,
  output logic [15:0]                        player_launch_cnt,
  output logic [15:0]                        monster_launch_cnt,
  output logic [15:0]                        denied_cnt
`endif
);

  localparam int unsigned IDX_W  = $clog2(NUM_MONSTER_REQ);
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCHED_P = 2'd1,
    SCHED_M = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                fire_q;
  logic                player_pending;
  logic                fire_rise;
  logic [CD_W-1:0]     player_cd, monster_cd;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    scan_idx;
  logic [IDX_W-1:0]    m_col;
  logic                m_found;
  logic [SLOT_W-1:0]   s_idx;
  logic                s_found;
  logic                p_grant, m_grant, sof_accept;
  logic [NUM_SLOTS-1:0] launch_vec;

  assign fire_rise = player_fire_req & ~fire_q;

  // Round-robin column pick starting at rr_ptr, and lowest free monster slot
  always_comb begin
    m_found  = 1'b0;
    m_col    = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_MONSTER_REQ; k++) begin
      scan_idx = IDX_W'((32'(rr_ptr) + k) % NUM_MONSTER_REQ);
      if (!m_found && monster_fire_req[scan_idx]) begin
        m_found = 1'b1;
        m_col   = scan_idx;
      end
    end
    s_found = 1'b0;
    s_idx   = '0;
    for (int unsigned s = 1; s < NUM_SLOTS; s++) begin
      if (!s_found && !slot_busy[SLOT_W'(s)]) begin
        s_found = 1'b1;
        s_idx   = SLOT_W'(s);
      end
    end
  end

  // Frame scheduler next-state and grant decisions
  always_comb begin
    state_next = state;
    p_grant    = 1'b0;
    m_grant    = 1'b0;
    sof_accept = 1'b0;
    launch_vec = '0;
    case (state)
      IDLE: begin
        if (startOfFrame && game_enable) begin
          state_next = SCHED_P;
          sof_accept = 1'b1;
        end
      end
      SCHED_P: begin
        state_next = SCHED_M;
        p_grant    = player_pending && !slot_busy[0] && (player_cd == '0);
      end
      SCHED_M: begin
        state_next = IDLE;
        m_grant    = m_found && s_found && (monster_cd == '0);
      end
      default: state_next = IDLE;
    endcase
    if (!game_enable) begin
      state_next = IDLE;
      p_grant    = 1'b0;
      m_grant    = 1'b0;
      sof_accept = 1'b0;
    end
    if (p_grant) launch_vec[0] = 1'b1;
    if (m_grant) launch_vec[s_idx] = 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Slot ownership, launch pulses, cooldowns and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_q         <= 1'b0;
      player_pending <= 1'b0;
      slot_busy      <= '0;
      slot_launch    <= '0;
      launch_src_idx <= '0;
      player_cd      <= '0;
      monster_cd     <= '0;
      rr_ptr         <= '0;
    end else begin
      fire_q      <= player_fire_req;
      slot_launch <= launch_vec;
      slot_busy   <= (slot_busy & ~slot_free) | launch_vec;
      // A pending shot is consumed by SCHED_P even when not granted
      if (!game_enable || state == SCHED_P) player_pending <= 1'b0;
      else if (fire_rise)                   player_pending <= 1'b1;
      if (p_grant)                            player_cd <= CD_W'(PLAYER_COOLDOWN);
      else if (sof_accept && player_cd != '0) player_cd <= player_cd - 1'b1;
      if (m_grant)                             monster_cd <= CD_W'(MONSTER_COOLDOWN);
      else if (sof_accept && monster_cd != '0) monster_cd <= monster_cd - 1'b1;
      if (m_grant) begin
        launch_src_idx <= m_col;
        rr_ptr         <= (m_col == IDX_W'(NUM_MONSTER_REQ - 1)) ? '0 : m_col + 1'b1;
      end
    end
  end

`ifdef ARBITER_STATS_EN
  logic denied_evt;
  assign denied_evt = game_enable &&
                      (((state == SCHED_P) && player_pending && !p_grant) ||
                       ((state == SCHED_M) && m_found && !m_grant));

  // Saturating launch and denial statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player_launch_cnt  <= '0;
      monster_launch_cnt <= '0;
      denied_cnt         <= '0;
    end else begin
      if (p_grant && player_launch_cnt != '1)  player_launch_cnt  <= player_launch_cnt + 1'b1;
      if (m_grant && monster_launch_cnt != '1) monster_launch_cnt <= monster_launch_cnt + 1'b1;
      if (denied_evt && denied_cnt != '1)      denied_cnt         <= denied_cnt + 1'b1;
    end
  end
`endif

endmodule
